exe1_out_buffer: RTL and testbench
==================================

Name: exe1_out_buffer

Overview:
- Two-entry elastic (skid) buffer between the EXE1 arithmetic stage output (D0..D3, mode, config) and the EXE2 stage input of a CGRA processing element.
- Decouples EXE1 from EXE2 backpressure with a valid/ready handshake on both sides.
- Supports synchronous flush for context switches.
- Provides a saturating stall counter for performance monitoring.

Parameters:
- DW, 64, data word width per lane (DWORD_BITS).
- CFG_W, 8, width of the forwarded EXE2 configuration field.
- SC_W, 16, width of the stall counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- flush_in  in  1  synchronous flush; empties the buffer.
- in_valid  in  1  EXE1 result valid.
- in_ready  out  1  buffer can accept this cycle.
- Mode_in  in  1  lane mode bit; forwarded unchanged, never interpreted.
- CFG_in  in  CFG_W  EXE2 configuration travelling with the data.
- S0_in..S3_in  in  DW each  EXE1 results D0..D3.
- out_valid  out  1  head entry valid toward EXE2.
- out_ready  in  1  EXE2 accepts head.
- Mode_out  out  1  head mode bit.
- CFG_out  out  CFG_W  head configuration.
- D0_out..D3_out  out  DW each  head data.
- count_out  out  2  occupancy, 0..2.
- stall_cnt_out  out  SC_W  saturating stall-cycle count.

Behaviour:
- Storage and occupancy:
  - Storage is two entries: head (H) and skid (K). Each entry holds {Mode, CFG, D0..D3}.
  - count is a register with values 0..2.
  - All outputs are registered or derived only from registers. There is no combinational path from in_* to out_* or from out_ready to in_ready.
- Handshake signals:
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - Outputs always present H.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Per-cycle update, applied in this priority order:
  - flush_in = 1: count -> 0; push and pop are ignored; data registers are unchanged.
  - count 0, push: H <- input; count -> 1. Latency in -> out is 1 cycle.
  - count 1, push only: K <- input; count -> 2.
  - count 1, pop only: count -> 0.
  - count 1, push and pop: H <- input; count stays 1. This gives full throughput of 1 item/cycle.
  - count 2, pop: H <- K; count -> 1. in_ready is 0 here, so no push can occur.
  - Neither push nor pop: hold.
- Ordering: strict FIFO; data is never reordered, duplicated or dropped while flush_in = 0.
- Stall counter:
  - Increments when out_valid & ~out_ready.
  - Saturates at 2^SC_W - 1.
  - Clears on flush_in.
  - Unaffected by any other event.
- Reset (RST = 0, asynchronous):
  - count = 0, so out_valid = 0 and in_ready = 1.
  - H, K, Mode_out, CFG_out, D*_out = 0.
  - stall_cnt_out = 0.
- Reset mid-transfer: in-flight entries are discarded; the first push after reset release appears on the outputs 1 cycle later.
- Flush and push in the same cycle: the input is dropped. The upstream stage must treat in_ready as still asserted that cycle and its item as consumed.
- Outputs hold stable while out_valid = 1 and out_ready = 0.

Test Plan:
- Reset release, push S0=0x1, S1=0x2, S2=0x3, S3=0x4, CFG=0x05, Mode=1 with out_ready=1 -> next cycle out_valid=1, D0..D3_out=1,2,3,4, CFG_out=0x05, Mode_out=1; following cycle count=0.
- Streaming 8 items with D0 = 10..17 and out_ready=1 every cycle -> 8 consecutive out_valid cycles, D0_out = 10..17 in order, count stays 1, in_ready never drops.
- Hold out_ready=0 and push A=0xA, B=0xB, C=0xC -> count=2 after B; in_ready=0 so C is not accepted (upstream holds it); outputs stay at A; stall_cnt_out increments every cycle from the first out_valid.
- Then raise out_ready -> outputs A, B, C on three consecutive cycles with no bubble after B; no loss or duplication.
- count=2, assert flush_in together with in_valid=1 -> next cycle count=0, out_valid=0, stall_cnt_out=0; the flushed input never appears.
- Hold out_ready=0 with out_valid=1 for 2^16+5 cycles -> stall_cnt_out saturates at 0xFFFF; assert RST mid-stall -> immediately out_valid=0, stall_cnt_out=0, in_ready=1.

Source files
------------

// File: rtl/exe1_out_buffer.sv
// ---------------------------------------------------------------------------
// exe1_out_buffer
//   Two-entry elastic (skid) buffer between the EXE1 arithmetic stage and the
//   EXE2 stage input of a CGRA processing element. Every output comes straight
//   from a register, so there is no combinational path from the upstream
//   inputs to the downstream outputs, and none from out_ready to in_ready.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   flush_in            synchronous flush: empties the buffer, clears stall count
//   in_valid/in_ready   EXE1 side handshake
//   Mode_in, CFG_in     sideband that travels with the data (never interpreted)
//   S0_in..S3_in        EXE1 results D0..D3
//   out_valid/out_ready EXE2 side handshake
//   Mode_out, CFG_out,
//   D0_out..D3_out      head entry contents
//   count_out           occupancy, 0..2
//   stall_cnt_out       saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module exe1_out_buffer #(
    parameter int DW    = 64,
    parameter int CFG_W = 8,
    parameter int SC_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             Mode_in,
    input  logic [CFG_W-1:0] CFG_in,
    input  logic [DW-1:0]    S0_in,
    input  logic [DW-1:0]    S1_in,
    input  logic [DW-1:0]    S2_in,
    input  logic [DW-1:0]    S3_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Mode_out,
    output logic [CFG_W-1:0] CFG_out,
    output logic [DW-1:0]    D0_out,
    output logic [DW-1:0]    D1_out,
    output logic [DW-1:0]    D2_out,
    output logic [DW-1:0]    D3_out,
    output logic [1:0]       count_out,
    output logic [SC_W-1:0]  stall_cnt_out
);

    typedef struct packed {
        logic             mode;
        logic [CFG_W-1:0] cfg;
        logic [DW-1:0]    d3;
        logic [DW-1:0]    d2;
        logic [DW-1:0]    d1;
        logic [DW-1:0]    d0;
    } entry_t;

    entry_t          h_q, h_d;     // head: always what the outputs present
    entry_t          k_q, k_d;     // skid: only meaningful when count == 2
    logic [1:0]      count_q, count_d;
    logic [SC_W-1:0] stall_q, stall_d;

    entry_t in_ent;
    logic   push, pop;

    assign in_ent = '{mode: Mode_in, cfg: CFG_in,
                      d3: S3_in, d2: S2_in, d1: S1_in, d0: S0_in};

    // Handshakes depend only on the occupancy register.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        h_d     = h_q;
        k_d     = k_q;
        count_d = count_q;
        if (flush_in) begin
            // Data registers keep their contents; only occupancy is dropped.
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        h_d     = in_ent;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        // Replace head in place: full 1 item/cycle throughput.
                        h_d = in_ent;
                    end else if (push) begin
                        k_d     = in_ent;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        h_d     = k_q;
                        count_d = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (flush_in)
            stall_d = '0;
        else if (out_valid && !out_ready && (stall_q != {SC_W{1'b1}}))
            stall_d = stall_q + SC_W'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            h_q     <= '0;
            k_q     <= '0;
            count_q <= 2'd0;
            stall_q <= '0;
        end else begin
            h_q     <= h_d;
            k_q     <= k_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    assign Mode_out      = h_q.mode;
    assign CFG_out       = h_q.cfg;
    assign D0_out        = h_q.d0;
    assign D1_out        = h_q.d1;
    assign D2_out        = h_q.d2;
    assign D3_out        = h_q.d3;
    assign count_out     = count_q;
    assign stall_cnt_out = stall_q;

endmodule

// File: tb/tb_exe1_out_buffer.sv
// ---------------------------------------------------------------------------
// tb_exe1_out_buffer
//   Self-checking bench for exe1_out_buffer. A queue-based model (at most two
//   items, FIFO order, saturating stall count) predicts the outputs; a compare
//   process checks them every falling edge. Directed sequences add literal
//   expectations, then a randomized phase exercises push/pop/flush mixes.
// ---------------------------------------------------------------------------
module tb_exe1_out_buffer;
    localparam int DW    = 64;
    localparam int CFG_W = 8;
    localparam int SC_W  = 16;
    localparam int SMAX  = (1 << SC_W) - 1;

    typedef struct packed {
        logic             mode;
        logic [CFG_W-1:0] cfg;
        logic [DW-1:0]    d3;
        logic [DW-1:0]    d2;
        logic [DW-1:0]    d1;
        logic [DW-1:0]    d0;
    } item_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             flush_in = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             Mode_in = 1'b0;
    logic [CFG_W-1:0] CFG_in = '0;
    logic [DW-1:0]    S0_in = '0, S1_in = '0, S2_in = '0, S3_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             Mode_out;
    logic [CFG_W-1:0] CFG_out;
    logic [DW-1:0]    D0_out, D1_out, D2_out, D3_out;
    logic [1:0]       count_out;
    logic [SC_W-1:0]  stall_cnt_out;

    int ntests = 0;
    int nfail  = 0;

    exe1_out_buffer #(.DW(DW), .CFG_W(CFG_W), .SC_W(SC_W)) dut (
        .CLK(CLK), .RST(RST), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .Mode_in(Mode_in), .CFG_in(CFG_in),
        .S0_in(S0_in), .S1_in(S1_in), .S2_in(S2_in), .S3_in(S3_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .Mode_out(Mode_out), .CFG_out(CFG_out),
        .D0_out(D0_out), .D1_out(D1_out), .D2_out(D2_out), .D3_out(D3_out),
        .count_out(count_out), .stall_cnt_out(stall_cnt_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic m, input logic [CFG_W-1:0] c,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [DW-1:0] e, input logic [DW-1:0] f);
        item_t it;
        it.mode = m; it.cfg = c; it.d0 = a; it.d1 = b; it.d2 = e; it.d3 = f;
        return it;
    endfunction

    function automatic item_t rnd_item();
        return mk(1'($urandom), CFG_W'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
    endfunction

    task automatic drive(input logic v, input item_t it);
        in_valid = v;
        Mode_in  = it.mode;
        CFG_in   = it.cfg;
        S0_in    = it.d0;
        S1_in    = it.d1;
        S2_in    = it.d2;
        S3_in    = it.d3;
    endtask

    // ---------------- behavioural model ----------------
    item_t       mq[$];
    int unsigned m_stall = 0;

    always @(posedge CLK or negedge RST) begin
        bit do_pop, do_push;
        if (!RST) begin
            mq.delete();
            m_stall = 0;
        end else if (flush_in) begin
            mq.delete();
            m_stall = 0;
        end else begin
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = in_valid && (mq.size() < 2);
            if (mq.size() > 0 && !out_ready && m_stall < SMAX) m_stall++;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(mk(Mode_in, CFG_in, S0_in, S1_in, S2_in, S3_in));
        end
    end

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        if (RST) begin
            chk("count", 64'(count_out), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("stall_cnt", 64'(stall_cnt_out), 64'(m_stall));
            if (mq.size() > 0) begin
                chk("mode", 64'(Mode_out), 64'(mq[0].mode));
                chk("cfg", 64'(CFG_out), 64'(mq[0].cfg));
                chk("d0", D0_out, mq[0].d0);
                chk("d1", D1_out, mq[0].d1);
                chk("d2", D2_out, mq[0].d2);
                chk("d3", D3_out, mq[0].d3);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        item_t cur;
        bit    cons;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_stall", 64'(stall_cnt_out), 64'd0);
        chk("rst_d0", D0_out, 64'd0);
        chk("rst_cfg", 64'(CFG_out), 64'd0);
        chk("rst_mode", 64'(Mode_out), 64'd0);
        RST = 1'b1;

        // Single item, 1-cycle latency
        @(negedge CLK);
        out_ready = 1'b1;
        drive(1'b1, mk(1'b1, 8'h05, 64'h1, 64'h2, 64'h3, 64'h4));
        @(negedge CLK);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_d0", D0_out, 64'h1);
        chk("t1_d1", D1_out, 64'h2);
        chk("t1_d2", D2_out, 64'h3);
        chk("t1_d3", D3_out, 64'h4);
        chk("t1_cfg", 64'(CFG_out), 64'h05);
        chk("t1_mode", 64'(Mode_out), 64'd1);
        drive(1'b0, '0);
        @(negedge CLK);
        chk("t1_count0", 64'(count_out), 64'd0);

        // Streaming 8 items at full rate
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                chk("t2_valid", 64'(out_valid), 64'd1);
                chk("t2_d0", D0_out, 64'(10 + i - 1));
                chk("t2_count", 64'(count_out), 64'd1);
            end
            chk("t2_in_ready", 64'(in_ready), 64'd1);
            if (i < 8) drive(1'b1, mk(1'b0, 8'h10, 64'(10 + i), 64'd0, 64'd0, 64'd0));
            else       drive(1'b0, '0);
            @(negedge CLK);
        end
        chk("t2_drain", 64'(count_out), 64'd0);

        // Backpressure: A, B fill, C held upstream
        out_ready = 1'b0;
        drive(1'b1, mk(1'b0, 8'h0A, 64'hA, 64'd0, 64'd0, 64'd0));
        @(negedge CLK);
        chk("t3_cnt1", 64'(count_out), 64'd1);
        chk("t3_headA", D0_out, 64'hA);
        chk("t3_stall0", 64'(stall_cnt_out), 64'd0);
        drive(1'b1, mk(1'b0, 8'h0B, 64'hB, 64'd0, 64'd0, 64'd0));
        @(negedge CLK);
        chk("t3_cnt2", 64'(count_out), 64'd2);
        chk("t3_in_ready0", 64'(in_ready), 64'd0);
        chk("t3_headA2", D0_out, 64'hA);
        chk("t3_stall1", 64'(stall_cnt_out), 64'd1);
        drive(1'b1, mk(1'b0, 8'h0C, 64'hC, 64'd0, 64'd0, 64'd0));
        @(negedge CLK);
        chk("t3_cnt2b", 64'(count_out), 64'd2);
        chk("t3_headA3", D0_out, 64'hA);
        chk("t3_stall2", 64'(stall_cnt_out), 64'd2);
        out_ready = 1'b1;
        @(negedge CLK);
        chk("t3_headB", D0_out, 64'hB);
        chk("t3_in_ready1", 64'(in_ready), 64'd1);
        @(negedge CLK);
        chk("t3_headC", D0_out, 64'hC);
        chk("t3_validC", 64'(out_valid), 64'd1);
        drive(1'b0, '0);
        @(negedge CLK);
        chk("t3_empty", 64'(count_out), 64'd0);
        chk("t3_stall_hold", 64'(stall_cnt_out), 64'd2);

        // Flush while full, together with a push
        out_ready = 1'b0;
        drive(1'b1, mk(1'b0, 8'h01, 64'h111, 64'd0, 64'd0, 64'd0));
        @(negedge CLK);
        drive(1'b1, mk(1'b0, 8'h02, 64'h222, 64'd0, 64'd0, 64'd0));
        @(negedge CLK);
        chk("t4_full", 64'(count_out), 64'd2);
        flush_in = 1'b1;
        drive(1'b1, mk(1'b0, 8'h03, 64'h333, 64'd0, 64'd0, 64'd0));
        @(negedge CLK);
        flush_in = 1'b0;
        chk("t4_count0", 64'(count_out), 64'd0);
        chk("t4_valid0", 64'(out_valid), 64'd0);
        chk("t4_stall0", 64'(stall_cnt_out), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, mk(1'b0, 8'h04, 64'h444, 64'd0, 64'd0, 64'd0));
        @(negedge CLK);
        chk("t4_next_item", D0_out, 64'h444);
        drive(1'b0, '0);
        @(negedge CLK);
        chk("t4_no_ghost", 64'(out_valid), 64'd0);

        // Randomized push/pop/flush mix
        cur  = rnd_item();
        cons = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (cons) cur = rnd_item();
            out_ready = ($urandom_range(0, 2) != 0);
            flush_in  = ($urandom_range(0, 31) == 0);
            drive($urandom_range(0, 3) != 0, cur);
            // in_ready is registered, so this is the value the next edge uses.
            cons = in_valid && (in_ready || flush_in);
            @(negedge CLK);
        end
        flush_in = 1'b0;
        drive(1'b0, '0);
        out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rnd_drained", 64'(count_out), 64'd0);

        // Stall counter saturation, then asynchronous reset mid-stall
        flush_in = 1'b1;
        @(negedge CLK);
        flush_in  = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, mk(1'b0, 8'h55, 64'h55, 64'd0, 64'd0, 64'd0));
        @(negedge CLK);
        drive(1'b0, '0);
        repeat (SMAX + 5) @(negedge CLK);
        chk("sat_stall", 64'(stall_cnt_out), 64'hFFFF);
        chk("sat_valid", 64'(out_valid), 64'd1);
        chk("sat_head", D0_out, 64'h55);
        #2 RST = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_stall", 64'(stall_cnt_out), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_count", 64'(count_out), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, mk(1'b1, 8'h77, 64'h99, 64'h98, 64'h97, 64'h96));
        @(negedge CLK);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_d0", D0_out, 64'h99);
        chk("post_rst_d3", D3_out, 64'h96);
        drive(1'b0, '0);
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
